// File: rtl/burst_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : burst_read_arbiter_pkg
// Brief   : Shared types and constants for the burst read arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package burst_read_arbiter_pkg;

    localparam int c_num_req  = 2;
    localparam int c_id_width = 1;

    typedef logic [c_id_width-1:0] id_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/burst_read_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Brief   : Two-way round-robin pick; pointer moves only when a grant is taken.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import burst_read_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [c_num_req-1:0] i_req,
    input  logic                 i_take,
    output logic                 o_valid,
    output id_t                  o_id,
    output logic [c_num_req-1:0] o_gnt
);

    id_t r_ptr_q;
    id_t w_ptr_d;
    id_t w_id;

    always_comb begin
        o_valid = |i_req;
        // On contention the pointer names the requester not served last.
        if (i_req == 2'b11) begin
            w_id = r_ptr_q;
        end else begin
            w_id = i_req[1];
        end
        o_id    = w_id;
        o_gnt   = o_valid ? (w_id ? 2'b10 : 2'b01) : 2'b00;
        w_ptr_d = r_ptr_q;
        if (i_take && o_valid) begin
            w_ptr_d = ~w_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/burst_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : burst_read_arbiter
// Brief   : Round-robin burst reader sharing BRAM port 0 between two users.
// Revision: 1.0 - initial release
// ============================================================================
module burst_read_arbiter
    import burst_read_arbiter_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 7,
    parameter int MEM_SIZE = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_i,
    input  logic [AWIDTH-1:0]    base0_i,
    input  logic [AWIDTH-1:0]    base1_i,
    input  logic [AWIDTH-1:0]    len0_i,
    input  logic [AWIDTH-1:0]    len1_i,
    output logic [1:0]           gnt_o,
    output logic [1:0]           done_o,
    output logic                 idle_o,
    output logic [AWIDTH-1:0]    mem_addr_o,
    output logic                 mem_ce_o,
    input  logic [DWIDTH-1:0]    mem_q_i,
    output logic [DWIDTH-1:0]    rd_data_o,
    output logic                 rd_valid_o,
    output logic                 rd_id_o
);

    localparam logic [AWIDTH:0] c_mem_size = (AWIDTH+1)'(MEM_SIZE);

    state_t              r_state_q, w_state_d;
    logic [AWIDTH-1:0]   r_addr_q,  w_addr_d;
    logic [AWIDTH-1:0]   r_cnt_q,   w_cnt_d;
    id_t                 r_owner_q, w_owner_d;
    logic                r_ce_q,    w_ce_d;
    logic [1:0]          r_gnt_q,   w_gnt_d;
    logic [1:0]          r_done_q,  w_done_d;
    logic                r_valid_q, w_valid_d;
    id_t                 r_rd_id_q, w_rd_id_d;

    logic                w_take;
    logic                w_win_valid;
    id_t                 w_win_id;
    logic [1:0]          w_win_gnt;
    logic [AWIDTH-1:0]   w_win_base;
    logic [AWIDTH-1:0]   w_win_len;
    logic [AWIDTH:0]     w_addr_inc;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (req_i),
        .i_take  (w_take),
        .o_valid (w_win_valid),
        .o_id    (w_win_id),
        .o_gnt   (w_win_gnt)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_addr_d   = r_addr_q;
        w_cnt_d    = r_cnt_q;
        w_owner_d  = r_owner_q;
        w_ce_d     = 1'b0;
        w_gnt_d    = r_gnt_q;
        w_done_d   = 2'b00;
        w_take     = 1'b0;
        w_win_base = w_win_id ? base1_i : base0_i;
        w_win_len  = w_win_id ? len1_i  : len0_i;
        // One extra bit keeps base+1 from overflowing before the wrap test.
        w_addr_inc = {1'b0, r_addr_q} + 1'b1;

        case (r_state_q)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_take    = 1'b1;
                    w_owner_d = w_win_id;
                    w_gnt_d   = w_win_gnt;
                    if (w_win_len == '0) begin
                        w_state_d = ST_DRAIN;
                        w_done_d  = w_win_gnt;
                    end else begin
                        w_state_d = ST_RUN;
                        w_ce_d    = 1'b1;
                        w_addr_d  = w_win_base;
                        w_cnt_d   = w_win_len - 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (r_cnt_q == '0) begin
                    w_state_d = ST_DRAIN;
                    w_done_d  = r_gnt_q;
                end else begin
                    w_ce_d   = 1'b1;
                    w_cnt_d  = r_cnt_q - 1'b1;
                    w_addr_d = (w_addr_inc == c_mem_size) ? '0 : w_addr_inc[AWIDTH-1:0];
                end
            end
            ST_DRAIN: begin
                w_state_d = ST_IDLE;
                w_gnt_d   = 2'b00;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_gnt_d   = 2'b00;
            end
        endcase

        w_valid_d = r_ce_q;
        w_rd_id_d = r_owner_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= ST_IDLE;
            r_addr_q  <= '0;
            r_cnt_q   <= '0;
            r_owner_q <= '0;
            r_ce_q    <= 1'b0;
            r_gnt_q   <= 2'b00;
            r_done_q  <= 2'b00;
            r_valid_q <= 1'b0;
            r_rd_id_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_addr_q  <= w_addr_d;
            r_cnt_q   <= w_cnt_d;
            r_owner_q <= w_owner_d;
            r_ce_q    <= w_ce_d;
            r_gnt_q   <= w_gnt_d;
            r_done_q  <= w_done_d;
            r_valid_q <= w_valid_d;
            r_rd_id_q <= w_rd_id_d;
        end
    end

    assign gnt_o      = r_gnt_q;
    assign done_o     = r_done_q;
    assign idle_o     = (r_state_q == ST_IDLE);
    assign mem_addr_o = r_addr_q;
    assign mem_ce_o   = r_ce_q;
    assign rd_data_o  = mem_q_i;
    assign rd_valid_o = r_valid_q;
    assign rd_id_o    = r_rd_id_q;

endmodule
`default_nettype wire

// File: tb/tb_burst_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_burst_read_arbiter
// Brief   : Directed and random burst checks against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_burst_read_arbiter;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int MS = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_i;
    logic [AW-1:0] base0_i, base1_i, len0_i, len1_i;
    logic [1:0]    gnt_o, done_o;
    logic          idle_o, mem_ce_o, rd_valid_o, rd_id_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_q, rd_data_o;

    logic [DW-1:0] mem [0:MS-1];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            exp_ptr = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_ce_o) mem_q <= mem[mem_addr_o];

    burst_read_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .base0_i    (base0_i),
        .base1_i    (base1_i),
        .len0_i     (len0_i),
        .len1_i     (len1_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .idle_o     (idle_o),
        .mem_addr_o (mem_addr_o),
        .mem_ce_o   (mem_ce_o),
        .mem_q_i    (mem_q),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .rd_id_o    (rd_id_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"},   gnt_o,      2'b00);
        chk({tag, "_done"},  done_o,     2'b00);
        chk({tag, "_idle"},  idle_o,     1'b1);
        chk({tag, "_ce"},    mem_ce_o,   1'b0);
        chk({tag, "_addr"},  mem_addr_o, '0);
        chk({tag, "_valid"}, rd_valid_o, 1'b0);
        chk({tag, "_id"},    rd_id_o,    1'b0);
    endtask

    // Called during an IDLE cycle; returns during the IDLE cycle after the burst.
    task automatic burst(input logic [1:0] req, input int b0, input int l0,
                         input int b1, input int l1, input logic [1:0] req_after);
        int         win, base, len;
        logic [1:0] oh;
        if (req == 2'b11) win = exp_ptr;
        else              win = (req == 2'b10) ? 1 : 0;
        exp_ptr = (win == 0) ? 1 : 0;
        base = win ? b1 : b0;
        len  = win ? l1 : l0;
        oh   = 2'b01 << win;
        req_i = req;
        base0_i = AW'(b0); len0_i = AW'(l0);
        base1_i = AW'(b1); len1_i = AW'(l1);
        step();
        req_i = req_after;
        for (int i = 0; i < len; i++) begin
            chk("run_gnt",  gnt_o,      oh);
            chk("run_ce",   mem_ce_o,   1'b1);
            chk("run_addr", mem_addr_o, (base + i) % MS);
            chk("run_idle", idle_o,     1'b0);
            chk("run_done", done_o,     2'b00);
            chk("run_valid", rd_valid_o, (i > 0) ? 1 : 0);
            if (i > 0) begin
                chk("run_data", rd_data_o, mem[(base + i - 1) % MS]);
                chk("run_id",   rd_id_o,   win);
            end
            step();
        end
        chk("drain_gnt",   gnt_o,      oh);
        chk("drain_ce",    mem_ce_o,   1'b0);
        chk("drain_done",  done_o,     oh);
        chk("drain_idle",  idle_o,     1'b0);
        chk("drain_valid", rd_valid_o, (len > 0) ? 1 : 0);
        if (len > 0) begin
            chk("drain_data", rd_data_o, mem[(base + len - 1) % MS]);
            chk("drain_id",   rd_id_o,   win);
        end
        step();
        chk("gap_idle",  idle_o,     1'b1);
        chk("gap_gnt",   gnt_o,      2'b00);
        chk("gap_done",  done_o,     2'b00);
        chk("gap_ce",    mem_ce_o,   1'b0);
        chk("gap_valid", rd_valid_o, 1'b0);
    endtask

    initial begin
        for (int a = 0; a < MS; a++) mem[a] = ($urandom() << 8) | a;
        rst_n = 1'b0; req_i = 2'b00;
        base0_i = '0; base1_i = '0; len0_i = '0; len1_i = '0;
        step(); step();
        rst_n = 1'b1;
        chk_reset_vals("reset");

        burst(2'b01, 5, 3, 0, 0, 2'b00);
        burst(2'b10, 0, 0, 98, 4, 2'b00);
        burst(2'b11, 0, 2, 50, 2, 2'b11);
        burst(2'b11, 0, 2, 50, 2, 2'b11);
        burst(2'b11, 0, 2, 50, 2, 2'b11);
        burst(2'b11, 0, 2, 50, 2, 2'b00);
        burst(2'b10, 0, 0, 30, 0, 2'b00);
        burst(2'b01, 40, 6, 0, 0, 2'b00);

        req_i = 2'b01; base0_i = AW'(20); len0_i = AW'(10);
        step();
        req_i = 2'b00;
        step();
        chk("mid_ce",   mem_ce_o,   1'b1);
        chk("mid_addr", mem_addr_o, 21);
        rst_n = 1'b0;
        step();
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        exp_ptr = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_valid", rd_valid_o, 1'b0);
            chk("post_done",  done_o,     2'b00);
            chk("post_idle",  idle_o,     1'b1);
        end
        burst(2'b11, 10, 2, 60, 2, 2'b00);

        for (int n = 0; n < 25; n++) begin
            burst(2'($urandom_range(1, 3)),
                  int'($urandom_range(0, MS - 1)), int'($urandom_range(0, 12)),
                  int'($urandom_range(0, MS - 1)), int'($urandom_range(0, 12)),
                  2'($urandom_range(0, 3)));
        end

        req_i = 2'b00;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
